// File: rtl/shot_resolver.sv
// shot_resolver: latches a placed 5x5 ship board and classifies each shot as miss/hit/sunk/repeat/invalid.
// Latency: shot accepted in cycle N, board read in N+1, result_valid pulse in N+2, shot_ready again in N+3.
// Backpressure: shot_ready is high only in READY; shots offered at any other time are dropped, never queued.
module shot_resolver #(
    parameter int BOARD_N   = 5,
    parameter int SHIPS_MAX = 5,
    parameter int CW        = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [BOARD_N*BOARD_N*CW-1:0] board_in,
    input  logic [CW-1:0]                 ship_q,
    input  logic [CW-1:0]                 x,
    input  logic [CW-1:0]                 y,
    input  logic                          shot_valid,
    output logic                          shot_ready,
    output logic                          result_valid,
    output logic                          hit,
    output logic                          sunk,
    output logic [CW-1:0]                 sunk_id,
    output logic                          repeat_shot,
    output logic                          invalid,
    output logic [3:0]                    cells_left,
    output logic                          all_sunk,
    output logic [BOARD_N*BOARD_N*2-1:0]  shot_map
);

    // Codes 0..2**CW-1 all get a remaining-cell slot so any board code can index
    // the counter array directly; slots outside 1..ships-in-play stay at zero.
    localparam int NCODES = 1 << CW;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READY  = 3'd1;
    localparam logic [2:0] S_EVAL   = 3'd2;
    localparam logic [2:0] S_REPORT = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] MARK_NONE = 2'd0;
    localparam logic [1:0] MARK_MISS = 2'd1;
    localparam logic [1:0] MARK_HIT  = 2'd2;

    logic [2:0]                    state;
    logic [BOARD_N*BOARD_N*CW-1:0] board_q;
    logic [CW-1:0]                 nships_q;
    logic [NCODES-1:0][CW-1:0]     rem;
    logic [CW-1:0]                 x_q;
    logic [CW-1:0]                 y_q;

    logic [CW-1:0] ships_clamped;
    logic [3:0]    load_cells;
    logic          coord_ok;
    int            cell_idx;
    logic [CW-1:0] cell_code;
    logic [1:0]    cell_mark;
    logic [CW-1:0] cell_rem;
    logic          code_in_play;
    logic          fresh_cell;
    logic          takes_hit;
    logic          sinks_ship;

    // Clamp the requested ship count and total the cells that a load will arm.
    always_comb begin
        ships_clamped = (int'(ship_q) > SHIPS_MAX) ? CW'(SHIPS_MAX) : ship_q;
        load_cells    = '0;
        for (int k = 1; k <= SHIPS_MAX; k++) begin
            if (k <= int'(ships_clamped)) begin
                load_cells = load_cells + 4'(k);
            end
        end
    end

    // Decode the latched shot against the latched board and the current shot map.
    // Out-of-range coordinates are redirected to cell 0 so the selects stay in bounds;
    // coord_ok gates every use of that decode.
    always_comb begin
        coord_ok     = (int'(x_q) < BOARD_N) && (int'(y_q) < BOARD_N);
        cell_idx     = coord_ok ? (int'(x_q) * BOARD_N + int'(y_q)) : 0;
        cell_code    = board_q[cell_idx*CW +: CW];
        cell_mark    = shot_map[cell_idx*2 +: 2];
        cell_rem     = rem[cell_code];
        code_in_play = (cell_code != '0) && (int'(cell_code) <= int'(nships_q)) && (cell_rem != '0);
        fresh_cell   = coord_ok && (cell_mark == MARK_NONE);
        takes_hit    = fresh_cell && code_in_play;
        sinks_ship   = takes_hit && (cell_rem == CW'(1));
    end

    // Control FSM; reset beats load, load beats any in-flight shot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (load) begin
            state <= (ships_clamped == '0) ? S_DONE : S_READY;
        end else begin
            case (state)
                S_READY:  if (shot_valid) state <= S_EVAL;
                S_EVAL:   state <= S_REPORT;
                S_REPORT: state <= (cells_left == '0) ? S_DONE : S_READY;
                default:  state <= state;
            endcase
        end
    end

    // Capture the coordinates of an accepted shot.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (!load && (state == S_READY) && shot_valid) begin
            x_q <= x;
            y_q <= y;
        end
    end

    // Board image, shot map and remaining-cell counters: armed by load, updated once per evaluated shot.
    // A hit needs rem[c] > 0, and cells_left is always the sum of rem[], so neither counter can underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            board_q    <= '0;
            nships_q   <= '0;
            rem        <= '0;
            cells_left <= '0;
            shot_map   <= '0;
        end else if (load) begin
            board_q    <= board_in;
            nships_q   <= ships_clamped;
            shot_map   <= '0;
            cells_left <= load_cells;
            for (int k = 0; k < NCODES; k++) begin
                rem[k] <= ((k >= 1) && (k <= int'(ships_clamped))) ? CW'(k) : '0;
            end
        end else if ((state == S_EVAL) && fresh_cell) begin
            if (takes_hit) begin
                shot_map[cell_idx*2 +: 2] <= MARK_HIT;
                rem[cell_code]            <= cell_rem - CW'(1);
                cells_left                <= cells_left - 4'd1;
            end else begin
                shot_map[cell_idx*2 +: 2] <= MARK_MISS;
            end
        end
    end

    // Result fields are computed in EVAL and then held until the next evaluated shot.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit         <= 1'b0;
            sunk        <= 1'b0;
            sunk_id     <= '0;
            repeat_shot <= 1'b0;
            invalid     <= 1'b0;
        end else if (!load && (state == S_EVAL)) begin
            invalid     <= !coord_ok;
            repeat_shot <= coord_ok && (cell_mark != MARK_NONE);
            hit         <= takes_hit || (coord_ok && (cell_mark == MARK_HIT));
            sunk        <= sinks_ship;
            sunk_id     <= sinks_ship ? cell_code : '0;
        end
    end

    assign shot_ready   = (state == S_READY);
    assign result_valid = (state == S_REPORT);
    assign all_sunk     = (state != S_IDLE) && (cells_left == '0);

endmodule

// File: tb/tb_shot_resolver.sv
// Directed bench for shot_resolver: table of shots on one board, plus reset,
// load-abort, held-valid, game-over and ship-count clamp sequences.
module tb_shot_resolver;

    localparam int N  = 5;
    localparam int CW = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  load;
    logic [N*N*CW-1:0]     board_in;
    logic [CW-1:0]         ship_q;
    logic [CW-1:0]         x;
    logic [CW-1:0]         y;
    logic                  shot_valid;
    logic                  shot_ready;
    logic                  result_valid;
    logic                  hit;
    logic                  sunk;
    logic [CW-1:0]         sunk_id;
    logic                  repeat_shot;
    logic                  invalid;
    logic [3:0]            cells_left;
    logic                  all_sunk;
    logic [N*N*2-1:0]      shot_map;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shot_resolver dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .board_in     (board_in),
        .ship_q       (ship_q),
        .x            (x),
        .y            (y),
        .shot_valid   (shot_valid),
        .shot_ready   (shot_ready),
        .result_valid (result_valid),
        .hit          (hit),
        .sunk         (sunk),
        .sunk_id      (sunk_id),
        .repeat_shot  (repeat_shot),
        .invalid      (invalid),
        .cells_left   (cells_left),
        .all_sunk     (all_sunk),
        .shot_map     (shot_map)
    );

    typedef struct {
        int sx;
        int sy;
        int hit;
        int sunk;
        int sunk_id;
        int rep;
        int inv;
        int cells;
        int map_cell;   // -1: coordinate off-board, no cell to inspect
        int marks;
        int all_sunk;
        int ready_after;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int marks_of(input logic [N*N*2-1:0] m);
        int c = 0;
        for (int i = 0; i < N*N; i++) begin
            if (m[i*2 +: 2] != 2'd0) c++;
        end
        return c;
    endfunction

    function automatic int map_at(input logic [N*N*2-1:0] m, input int r, input int c);
        return int'(m[(r*N+c)*2 +: 2]);
    endfunction

    function automatic logic [N*N*CW-1:0] make_board();
        logic [N*N*CW-1:0] b = '0;
        b[(0*N+0)*CW +: CW] = 3'd1;
        b[(1*N+1)*CW +: CW] = 3'd2;
        b[(1*N+2)*CW +: CW] = 3'd2;
        b[(2*N+2)*CW +: CW] = 3'd6;
        b[(3*N+3)*CW +: CW] = 3'd3;
        return b;
    endfunction

    // Called at a negedge; returns at the negedge after the load edge.
    task automatic do_load(input logic [N*N*CW-1:0] b, input int nq);
        board_in = b;
        ship_q   = CW'(nq);
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the REPORT cycle.
    task automatic fire(input int sx, input int sy, input string tag, output bit ok);
        int waitc = 0;
        ok = 1'b0;
        while (!shot_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!shot_ready) begin
            check({tag, " ready_timeout"}, int'(shot_ready), 1);
            return;
        end
        x          = CW'(sx);
        y          = CW'(sy);
        shot_valid = 1'b1;
        @(negedge clk);
        shot_valid = 1'b0;
        check({tag, " no_result_in_eval"}, int'(result_valid), 0);
        @(negedge clk);
        check({tag, " result_valid_at_accept+2"}, int'(result_valid), 1);
        ok = 1'b1;
    endtask

    vec_t v[9];

    initial begin
        bit ok;
        int pulses;
        int ready_seen;

        v[0] = '{0, 0, 1, 1, 1, 0, 0, 2, 2, 1, 0, 1};
        v[1] = '{4, 4, 0, 0, 0, 0, 0, 2, 1, 2, 0, 1};
        v[2] = '{4, 4, 0, 0, 0, 1, 0, 2, 1, 2, 0, 1};
        v[3] = '{0, 0, 1, 0, 0, 1, 0, 2, 2, 2, 0, 1};
        v[4] = '{5, 2, 0, 0, 0, 0, 1, 2, -1, 2, 0, 1};
        v[5] = '{2, 2, 0, 0, 0, 0, 0, 2, 1, 3, 0, 1};
        v[6] = '{3, 3, 0, 0, 0, 0, 0, 2, 1, 4, 0, 1};
        v[7] = '{1, 1, 1, 0, 0, 0, 0, 1, 2, 5, 0, 1};
        v[8] = '{1, 2, 1, 1, 2, 0, 0, 0, 2, 6, 1, 0};

        rst        = 1'b1;
        load       = 1'b0;
        board_in   = '0;
        ship_q     = '0;
        x          = '0;
        y          = '0;
        shot_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset wins over a simultaneous load.
        board_in = make_board();
        ship_q   = 3'd2;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        check("rst_over_load shot_ready", int'(shot_ready), 0);
        check("rst_over_load cells_left", int'(cells_left), 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset shot_ready", int'(shot_ready), 0);
        check("reset result_valid", int'(result_valid), 0);
        check("reset cells_left", int'(cells_left), 0);
        check("reset all_sunk", int'(all_sunk), 0);
        check("reset hit", int'(hit), 0);
        check("reset map_marks", marks_of(shot_map), 0);

        // Table-driven shots on the reference board.
        do_load(make_board(), 2);
        check("load cells_left", int'(cells_left), 3);
        check("load shot_ready", int'(shot_ready), 1);
        check("load map_marks", marks_of(shot_map), 0);
        check("load all_sunk", int'(all_sunk), 0);

        for (int i = 0; i < 9; i++) begin
            fire(v[i].sx, v[i].sy, $sformatf("v%0d", i), ok);
            if (ok) begin
                check($sformatf("v%0d hit", i), int'(hit), v[i].hit);
                check($sformatf("v%0d sunk", i), int'(sunk), v[i].sunk);
                check($sformatf("v%0d sunk_id", i), int'(sunk_id), v[i].sunk_id);
                check($sformatf("v%0d repeat_shot", i), int'(repeat_shot), v[i].rep);
                check($sformatf("v%0d invalid", i), int'(invalid), v[i].inv);
                check($sformatf("v%0d cells_left", i), int'(cells_left), v[i].cells);
                check($sformatf("v%0d all_sunk", i), int'(all_sunk), v[i].all_sunk);
                check($sformatf("v%0d map_marks", i), marks_of(shot_map), v[i].marks);
                if (v[i].map_cell >= 0) begin
                    check($sformatf("v%0d map_cell", i), map_at(shot_map, v[i].sx, v[i].sy), v[i].map_cell);
                end
            end
            @(negedge clk);
            check($sformatf("v%0d result_valid_one_cycle", i), int'(result_valid), 0);
            check($sformatf("v%0d shot_ready_after", i), int'(shot_ready), v[i].ready_after);
        end

        // Game over: further shots are ignored.
        x          = 3'd4;
        y          = 3'd0;
        shot_valid = 1'b1;
        pulses     = 0;
        ready_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (result_valid) pulses++;
            if (shot_ready) ready_seen++;
        end
        shot_valid = 1'b0;
        check("done result_pulses", pulses, 0);
        check("done shot_ready_seen", ready_seen, 0);
        check("done all_sunk", int'(all_sunk), 1);
        check("done map_marks", marks_of(shot_map), 6);

        // shot_valid held through EVAL/REPORT consumes one shot only.
        do_load(make_board(), 2);
        check("reload map_marks", marks_of(shot_map), 0);
        x          = 3'd4;
        y          = 3'd4;
        shot_valid = 1'b1;
        pulses     = 0;
        repeat (3) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        shot_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        check("held_valid result_pulses", pulses, 1);
        check("held_valid map_marks", marks_of(shot_map), 1);
        check("held_valid map_4_4", map_at(shot_map, 4, 4), 1);

        // Load during EVAL aborts the shot with no result pulse.
        x          = 3'd0;
        y          = 3'd0;
        shot_valid = 1'b1;
        @(negedge clk);
        shot_valid = 1'b0;
        check("abort in_eval shot_ready", int'(shot_ready), 0);
        do_load(make_board(), 2);
        check("abort result_valid", int'(result_valid), 0);
        check("abort shot_ready", int'(shot_ready), 1);
        check("abort cells_left", int'(cells_left), 3);
        check("abort map_marks", marks_of(shot_map), 0);
        @(negedge clk);
        check("abort no_late_result", int'(result_valid), 0);

        // Ship count clamp and empty fleet.
        do_load(make_board(), 7);
        check("clamp cells_left", int'(cells_left), 15);
        check("clamp shot_ready", int'(shot_ready), 1);
        do_load(make_board(), 0);
        check("zero_ships cells_left", int'(cells_left), 0);
        check("zero_ships all_sunk", int'(all_sunk), 1);
        check("zero_ships shot_ready", int'(shot_ready), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
